// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the 5-stage RV32 pipeline.
//
// Drives the load enables and bubble (flush) controls of the four
// inter-stage registers and the PC. It resolves three hazards:
//   - load-use: one stall cycle, with a bubble loaded into decode/execute;
//   - taken branch resolved in MEM: PC redirect, and the three younger
//     stage registers are flushed;
//   - slow data memory: the front of the pipeline freezes; the wait is
//     bounded by MEM_TIMEOUT.
// It also keeps saturating stall and flush counters for performance analysis.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   id_rs1/id_rs2         source registers of the decode instruction
//   id_use_rs1/id_use_rs2 the decode instruction really reads rs1/rs2
//   ex_memread, ex_rd     load flag and rd of the instruction in EX
//   mem_branch            branch code in MEM (0 none, 1 beq, 2 bne,
//                         3 blt, 4 bge, 5 jal/jalr)
//   mem_zero, mem_neg     ALU flags of the instruction in MEM
//   mem_memread/memwrite  memory operation of the instruction in MEM
//   dmem_ready            data memory finishes its access this cycle
//   pc_en, pc_redirect    PC load enable; select the branch target
//   *_en, *_flush         stage register load enables and bubble loads
//   halted                memory timeout; frozen until reset
//   stall_cnt, flush_cnt  saturating performance counters
//   dbg_state             FSM state (0 RUN, 1 MWAIT, 2 HALT)
//
// The control outputs are combinational from the registered state and the
// current-cycle inputs. They take effect at the next rising edge.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic [2:0]       mem_branch,
  input  logic             mem_zero,
  input  logic             mem_neg,
  input  logic             mem_memread,
  input  logic             mem_memwrite,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             fd_en,
  output logic             de_en,
  output logic             em_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             em_flush,
  output logic             mw_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  // The RUN cycle that enters MWAIT is the first wait cycle. The MWAIT cycle
  // holding this count is therefore wait cycle number MEM_TIMEOUT.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 2);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic branch_taken;
  logic load_use;
  logic mem_busy;
  logic branch_row;

  always_comb begin
    case (mem_branch)
      3'b001:  branch_taken = mem_zero;
      3'b010:  branch_taken = !mem_zero;
      3'b011:  branch_taken = mem_neg;
      3'b100:  branch_taken = !mem_neg;
      3'b101:  branch_taken = 1'b1;
      default: branch_taken = 1'b0;
    endcase
  end

  // x0 is never a real dependency. A store in EX has ex_memread=0.
  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    (((ex_rd == id_rs1) && id_use_rs1) ||
                     ((ex_rd == id_rs2) && id_use_rs2));

  assign mem_busy = (mem_memread || mem_memwrite) && !dmem_ready;

  // Priority: reset, halt, memory freeze, taken branch, load-use, normal.
  always_comb begin
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    fd_en       = 1'b0;
    de_en       = 1'b0;
    em_en       = 1'b0;
    mw_en       = 1'b0;
    fd_flush    = 1'b0;
    de_flush    = 1'b0;
    em_flush    = 1'b0;
    mw_flush    = 1'b0;
    branch_row  = 1'b0;
    if (reset) begin
      fd_flush = 1'b1;
      de_flush = 1'b1;
      em_flush = 1'b1;
      mw_flush = 1'b1;
    end else if (state_q == ST_HALT) begin
      // All controls stay low; everything is frozen.
    end else if (mem_busy) begin
      // The access in MEM is held in place. Writeback receives a bubble so
      // that the older instruction does not write back twice.
      mw_en    = 1'b1;
      mw_flush = 1'b1;
    end else if (branch_taken) begin
      // This also squashes a decode instruction stalled on load-use.
      pc_en       = 1'b1;
      pc_redirect = 1'b1;
      fd_en       = 1'b1;
      de_en       = 1'b1;
      em_en       = 1'b1;
      mw_en       = 1'b1;
      fd_flush    = 1'b1;
      de_flush    = 1'b1;
      em_flush    = 1'b1;
      branch_row  = 1'b1;
    end else if (load_use) begin
      de_en    = 1'b1;
      em_en    = 1'b1;
      mw_en    = 1'b1;
      de_flush = 1'b1;
    end else begin
      pc_en = 1'b1;
      fd_en = 1'b1;
      de_en = 1'b1;
      em_en = 1'b1;
      mw_en = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_RUN: begin
        wait_d = '0;
        if (mem_busy) state_d = ST_MWAIT;
      end
      ST_MWAIT: begin
        if (!mem_busy) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Reset and HALT never reach these increments: the reset branch of the
  // register block has priority, and HALT forces pc_en low from a state that
  // is excluded here.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q != ST_HALT) && !pc_en && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (branch_row && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halted    = (state_q == ST_HALT);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and randomized checks of pipeline_ctrl against a
// behavioural model. The model tracks the number of consecutive memory-wait
// cycles and the two saturating counters, and derives the controls from the
// priority rules.
module tb_pipeline_ctrl;

  localparam int MT   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_memread;
  logic [2:0]    mem_branch;
  logic          mem_zero, mem_neg, mem_memread, mem_memwrite, dmem_ready;
  logic          pc_en, pc_redirect, fd_en, de_en, em_en, mw_en;
  logic          fd_flush, de_flush, em_flush, mw_flush, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [1:0]    dbg_state;

  pipeline_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_neg(mem_neg),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .dmem_ready(dmem_ready),
    .pc_en(pc_en), .pc_redirect(pc_redirect),
    .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
    .fd_flush(fd_flush), .de_flush(de_flush),
    .em_flush(em_flush), .mw_flush(mw_flush),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int tests = 0;
  int fails = 0;
  logic [10:0] exp_q[$];

  int streak;     // consecutive cycles with a busy memory access
  bit halted_m;
  int stall_m;
  int flush_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit taken_m();
    case (mem_branch)
      3'd1: return mem_zero;
      3'd2: return !mem_zero;
      3'd3: return mem_neg;
      3'd4: return !mem_neg;
      3'd5: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit lu_m();
    return ex_memread && (ex_rd != 0) &&
           ((ex_rd == id_rs1 && id_use_rs1) || (ex_rd == id_rs2 && id_use_rs2));
  endfunction

  function automatic bit busy_m();
    return (mem_memread || mem_memwrite) && !dmem_ready;
  endfunction

  // {pc_en, pc_redirect, fd/de/em/mw_en, fd/de/em/mw_flush, halted}
  function automatic logic [10:0] exp_ctrl();
    if (reset)     return 11'b0_0_0000_1111_0;
    if (halted_m)  return 11'b0_0_0000_0000_1;
    if (busy_m())  return 11'b0_0_0001_0001_0;
    if (taken_m()) return 11'b1_1_1111_1110_0;
    if (lu_m())    return 11'b0_0_0111_0100_0;
    return 11'b1_0_1111_0000_0;
  endfunction

  task automatic model_clear();
    streak   = 0;
    halted_m = 1'b0;
    stall_m  = 0;
    flush_m  = 0;
  endtask

  task automatic model_advance(input logic [10:0] e);
    if (reset) begin
      model_clear();
      return;
    end
    if (!halted_m) begin
      if (!e[10] && stall_m < CMAX) stall_m++;
      if (e[9] && flush_m < CMAX) flush_m++;
      if (busy_m()) begin
        streak++;
        if (streak >= MT) halted_m = 1'b1;
      end else begin
        streak = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_memread = 0; ex_rd = 0;
    mem_branch = 0; mem_zero = 0; mem_neg = 0;
    mem_memread = 0; mem_memwrite = 0; dmem_ready = 1;
  endtask

  task automatic set_load_use();
    ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; id_rs1 = 3; id_use_rs1 = 1;
  endtask

  // Called at a falling edge with inputs already driven. Checks the current
  // cycle, advances the model across the rising edge, and returns at the next
  // falling edge.
  task automatic step(input string tag);
    logic [10:0] e;
    logic [10:0] got;
    int st;
    #2;
    if (reset) model_clear();
    exp_q.push_back(exp_ctrl());
    e   = exp_q.pop_front();
    got = {pc_en, pc_redirect, fd_en, de_en, em_en, mw_en,
           fd_flush, de_flush, em_flush, mw_flush, halted};
    st  = halted_m ? 2 : (streak > 0 ? 1 : 0);
    chk({tag, ":ctrl"}, 32'(got), 32'(e));
    chk({tag, ":state"}, 32'(dbg_state), 32'(st));
    chk({tag, ":stall_cnt"}, 32'(stall_cnt), 32'(stall_m));
    chk({tag, ":flush_cnt"}, 32'(flush_cnt), 32'(flush_m));
    model_advance(e);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    reset = 1;
    step("rst");
    reset = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    clear_inputs();
    reset = 1;
    @(negedge clk);
    step("reset0");
    step("reset1");
    reset = 0;
    step("idle");

    // Load-use: one stall cycle, and then normal flow.
    set_load_use();
    step("lu");
    clear_inputs();
    step("lu_after");
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    // Neither x0 nor a store in EX stalls.
    set_load_use(); ex_rd = 0; id_rs2 = 0;
    step("lu_x0");
    set_load_use(); ex_memread = 0;
    step("store_ex");
    clear_inputs();

    // Branches.
    mem_branch = 3'd1; mem_zero = 1;
    step("beq_taken");
    chk("beq_flush_cnt", 32'(flush_cnt), 32'd1);
    mem_zero = 0;
    step("beq_not_taken");
    chk("beq_nt_flush_cnt", 32'(flush_cnt), 32'd1);
    mem_branch = 3'd3; mem_neg = 1;
    step("blt_taken");
    mem_branch = 3'd2; mem_zero = 0;
    step("bne_taken");
    mem_branch = 3'd4; mem_neg = 1;
    step("bge_not_taken");
    mem_branch = 3'd6;
    step("code6");
    mem_branch = 3'd7;
    step("code7");
    // A taken branch combined with load-use: the branch wins and there is no stall.
    mem_branch = 3'd5; set_load_use();
    step("br_lu");
    chk("br_lu_stall_cnt", 32'(stall_cnt), 32'd1);
    clear_inputs();

    // Memory wait: 3 frozen cycles, then the pipeline advances.
    reset_pulse();
    mem_memread = 1; dmem_ready = 0;
    repeat (3) step("mwait");
    dmem_ready = 1;
    step("mready");
    chk("mwait_stall_cnt", 32'(stall_cnt), 32'd3);
    // A branch pending behind a busy store must not redirect until the access completes.
    mem_memread = 0; mem_memwrite = 1; dmem_ready = 0; mem_branch = 3'd5;
    step("busy_branch");
    dmem_ready = 1;
    step("busy_branch_done");
    clear_inputs();

    // Timeout leads to HALT. Asynchronous reset releases it.
    reset_pulse();
    mem_memread = 1; dmem_ready = 0;
    repeat (6) step("timeout");
    chk("timeout_halted", 32'(halted), 32'd1);
    dmem_ready = 1;
    step("halt_sticky");
    #3 reset = 1;
    #1;
    chk("arst_halted", 32'(halted), 32'd0);
    chk("arst_flush", 32'({fd_flush, de_flush, em_flush, mw_flush}), 32'hf);
    chk("arst_en", 32'({pc_en, fd_en, de_en, em_en, mw_en, pc_redirect}), 32'd0);
    chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    clear_inputs();
    step("arst_hold");
    reset = 0;

    // Saturation of stall_cnt.
    set_load_use();
    repeat (20) step("sat");
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    clear_inputs();

    // Randomized bursts, each starting from reset.
    repeat (8) begin
      reset_pulse();
      repeat (16) begin
        id_rs1       = 5'($urandom_range(0, 3));
        id_rs2       = 5'($urandom_range(0, 3));
        id_use_rs1   = 1'($urandom_range(0, 1));
        id_use_rs2   = 1'($urandom_range(0, 1));
        ex_memread   = 1'($urandom_range(0, 1));
        ex_rd        = 5'($urandom_range(0, 3));
        mem_branch   = 3'($urandom_range(0, 7));
        mem_zero     = 1'($urandom_range(0, 1));
        mem_neg      = 1'($urandom_range(0, 1));
        mem_memread  = ($urandom_range(0, 2) == 0);
        mem_memwrite = ($urandom_range(0, 3) == 0);
        dmem_ready   = ($urandom_range(0, 2) != 0);
        step("rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
